// File: rtl/video_timing_gen.sv
// Runtime-programmable raster timing generator: h/v counters, valid/ready mode
// loading applied only at frame wrap, and PIPE-delayed hsync/vsync/de.
module video_timing_gen #(
  parameter int unsigned CW         = 12,
  parameter int unsigned PIPE       = 2,
  parameter int unsigned DEF_H_ACT  = 800,
  parameter int unsigned DEF_H_FP   = 40,
  parameter int unsigned DEF_H_SYNC = 128,
  parameter int unsigned DEF_H_BP   = 88,
  parameter int unsigned DEF_V_ACT  = 600,
  parameter int unsigned DEF_V_FP   = 1,
  parameter int unsigned DEF_V_SYNC = 4,
  parameter int unsigned DEF_V_BP   = 23,
  parameter int unsigned DEF_HS_POL = 1,
  parameter int unsigned DEF_VS_POL = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] cfg_h_act,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_act,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
  input  logic          cfg_hs_pol,
  input  logic          cfg_vs_pol,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          cfg_applied,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          req_valid,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          de
);

  localparam int unsigned TW = CW + 2;
  localparam logic DEF_HS = 1'(DEF_HS_POL);
  localparam logic DEF_VS = 1'(DEF_VS_POL);

  typedef struct packed {
    logic [CW-1:0] h_act, h_fp, h_sync, h_bp;
    logic [CW-1:0] v_act, v_fp, v_sync, v_bp;
    logic          hs_pol, vs_pol;
  } mode_t;

  localparam mode_t DEF_MODE = '{
    h_act: CW'(DEF_H_ACT), h_fp: CW'(DEF_H_FP), h_sync: CW'(DEF_H_SYNC), h_bp: CW'(DEF_H_BP),
    v_act: CW'(DEF_V_ACT), v_fp: CW'(DEF_V_FP), v_sync: CW'(DEF_V_SYNC), v_bp: CW'(DEF_V_BP),
    hs_pol: DEF_HS, vs_pol: DEF_VS};

  typedef enum logic {CFG_OPEN, CFG_PENDING} cfg_state_t;

  cfg_state_t    state, state_nxt;
  mode_t         shadow, pending, cfg_mode;
  logic [TW-1:0] hc, vc, h_total, v_total;
  logic [TW-1:0] hs_start, hs_end, vs_start, vs_end;
  logic          h_wrap, v_wrap, frame_wrap, cfg_fire, cfg_zero, apply, apply_d;
  logic          active, hs_r, vs_r, de_r;

  assign cfg_mode = '{
    h_act: cfg_h_act, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
    v_act: cfg_v_act, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
    hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};

  assign h_total  = TW'(shadow.h_act) + TW'(shadow.h_fp) + TW'(shadow.h_sync) + TW'(shadow.h_bp);
  assign v_total  = TW'(shadow.v_act) + TW'(shadow.v_fp) + TW'(shadow.v_sync) + TW'(shadow.v_bp);
  assign hs_start = TW'(shadow.h_act) + TW'(shadow.h_fp);
  assign hs_end   = hs_start + TW'(shadow.h_sync);
  assign vs_start = TW'(shadow.v_act) + TW'(shadow.v_fp);
  assign vs_end   = vs_start + TW'(shadow.v_sync);

  assign h_wrap     = (hc == h_total - TW'(1));
  assign v_wrap     = (vc == v_total - TW'(1));
  assign frame_wrap = h_wrap && v_wrap;
  assign active     = (hc < TW'(shadow.h_act)) && (vc < TW'(shadow.v_act));

  assign cfg_ready = (state == CFG_OPEN);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_zero  = (cfg_h_act == '0) || (cfg_h_fp == '0) || (cfg_h_sync == '0) ||
                     (cfg_h_bp == '0) || (cfg_v_act == '0) || (cfg_v_fp == '0) ||
                     (cfg_v_sync == '0) || (cfg_v_bp == '0);
  assign apply     = frame_wrap && (state == CFG_PENDING);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= CFG_OPEN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CFG_OPEN:    if (cfg_fire && !cfg_zero) state_nxt = CFG_PENDING;
      CFG_PENDING: if (frame_wrap) state_nxt = CFG_OPEN;
      default:     state_nxt = CFG_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow      <= DEF_MODE;
      pending     <= '0;
      hc          <= '0;
      vc          <= '0;
      apply_d     <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_applied <= 1'b0;
      x           <= '0;
      y           <= '0;
      req_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_r        <= ~DEF_HS;
      vs_r        <= ~DEF_VS;
      de_r        <= 1'b0;
    end else begin
      if (cfg_fire && !cfg_zero) pending <= cfg_mode;
      if (apply) shadow <= pending;
      if (h_wrap) begin
        hc <= '0;
        vc <= v_wrap ? '0 : vc + TW'(1);
      end else begin
        hc <= hc + TW'(1);
      end
      cfg_err <= cfg_fire && cfg_zero;
      // apply_d lines cfg_applied up with the frame_start of the (0,0) state
      apply_d     <= apply;
      cfg_applied <= apply_d;
      x           <= active ? hc[CW-1:0] : '0;
      y           <= active ? vc[CW-1:0] : '0;
      req_valid   <= active;
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);
      hs_r        <= ((hc >= hs_start) && (hc < hs_end)) ? shadow.hs_pol : ~shadow.hs_pol;
      vs_r        <= ((vc >= vs_start) && (vc < vs_end)) ? shadow.vs_pol : ~shadow.vs_pol;
      de_r        <= active;
    end
  end

  if (PIPE == 0) begin : g_nopipe
    assign hsync = hs_r;
    assign vsync = vs_r;
    assign de    = de_r;
  end else begin : g_pipe
    logic [PIPE-1:0] hs_p, vs_p, de_p;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        hs_p <= {PIPE{~DEF_HS}};
        vs_p <= {PIPE{~DEF_VS}};
        de_p <= '0;
      end else begin
        hs_p[0] <= hs_r;
        vs_p[0] <= vs_r;
        de_p[0] <= de_r;
        for (int unsigned i = 1; i < PIPE; i++) begin
          hs_p[i] <= hs_p[i-1];
          vs_p[i] <= vs_p[i-1];
          de_p[i] <= de_p[i-1];
        end
      end
    end
    assign hsync = hs_p[PIPE-1];
    assign vsync = vs_p[PIPE-1];
    assign de    = de_p[PIPE-1];
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a frame-position reference model pushes
// expected outputs each cycle; a monitor pops and compares every output.
module tb_video_timing_gen;
  localparam int CW = 12, PIPE = 2;
  localparam int DHA = 800, DHF = 40, DHS = 128, DHB = 88;
  localparam int DVA = 6, DVF = 1, DVS = 2, DVB = 1;
  localparam bit DHP = 1, DVP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, cfg_valid, cfg_hs_pol, cfg_vs_pol;
  logic [CW-1:0] cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [CW-1:0] cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic          cfg_ready, cfg_err, cfg_applied, req_valid, line_start, frame_start;
  logic          hsync, vsync, de;
  logic [CW-1:0] x, y;

  video_timing_gen #(
    .CW(CW), .PIPE(PIPE),
    .DEF_H_ACT(DHA), .DEF_H_FP(DHF), .DEF_H_SYNC(DHS), .DEF_H_BP(DHB),
    .DEF_V_ACT(DVA), .DEF_V_FP(DVF), .DEF_V_SYNC(DVS), .DEF_V_BP(DVB),
    .DEF_HS_POL(1), .DEF_VS_POL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cfg_applied(cfg_applied),
    .x(x), .y(y), .req_valid(req_valid), .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .de(de)
  );

  typedef struct {int ha, hf, hs, hb, va, vf, vs, vb; bit hp, vp;} mode_t;
  typedef struct {int x, y; bit rv, ls, fs, hs, vs, de, rdy, err, app;} exp_t;

  exp_t  sbq[$];
  bit    hist_hs[$], hist_vs[$], hist_de[$];
  mode_t m_cur, m_pend;
  bit    m_pv, m_app_d;
  int    m_t;
  int    errors = 0, checks = 0;

  function automatic mode_t mk(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb,
                               bit hp, bit vp);
    mode_t m;
    m.ha = ha; m.hf = hf; m.hs = hs; m.hb = hb;
    m.va = va; m.vf = vf; m.vs = vs; m.vb = vb;
    m.hp = hp; m.vp = vp;
    return m;
  endfunction

  function automatic int htot(mode_t m); return m.ha + m.hf + m.hs + m.hb; endfunction
  function automatic int vtot(mode_t m); return m.va + m.vf + m.vs + m.vb; endfunction

  // Reference model: frame position m_t advances one pixel per clock; sync/de
  // delay is a PIPE-deep FIFO of undelayed values.
  always @(negedge clk) begin
    exp_t e;
    int ht, vt, h, v;
    bit act, pend_old, accept, zero, app_now;
    mode_t c;
    e = '{default: 0};
    if (!reset_n) begin
      m_cur = mk(DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, DHP, DVP);
      m_pv = 0; m_t = 0; m_app_d = 0;
      hist_hs.delete(); hist_vs.delete(); hist_de.delete();
      for (int i = 0; i < PIPE; i++) begin
        hist_hs.push_back(!DHP); hist_vs.push_back(!DVP); hist_de.push_back(0);
      end
      e.hs = !DHP; e.vs = !DVP; e.rdy = 1;
    end else begin
      ht = htot(m_cur); vt = vtot(m_cur);
      h = m_t % ht; v = m_t / ht;
      act = (h < m_cur.ha) && (v < m_cur.va);
      e.rv = act; e.x = act ? h : 0; e.y = act ? v : 0;
      e.ls = (h == 0); e.fs = (m_t == 0);
      hist_hs.push_back(((h >= m_cur.ha + m_cur.hf) && (h < m_cur.ha + m_cur.hf + m_cur.hs))
                        ? m_cur.hp : !m_cur.hp);
      hist_vs.push_back(((v >= m_cur.va + m_cur.vf) && (v < m_cur.va + m_cur.vf + m_cur.vs))
                        ? m_cur.vp : !m_cur.vp);
      hist_de.push_back(act);
      e.hs = hist_hs.pop_front(); e.vs = hist_vs.pop_front(); e.de = hist_de.pop_front();
      e.app = m_app_d;
      c = mk(int'(cfg_h_act), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp),
             int'(cfg_v_act), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp),
             cfg_hs_pol, cfg_vs_pol);
      zero = (c.ha == 0) || (c.hf == 0) || (c.hs == 0) || (c.hb == 0) ||
             (c.va == 0) || (c.vf == 0) || (c.vs == 0) || (c.vb == 0);
      pend_old = m_pv;
      accept = cfg_valid && !pend_old;
      e.err = accept && zero;
      app_now = (m_t == ht * vt - 1) && pend_old;
      if (accept && !zero) begin m_pv = 1; m_pend = c; end
      if (app_now) begin m_cur = m_pend; m_pv = 0; end
      m_t = (m_t == ht * vt - 1) ? 0 : m_t + 1;
      m_app_d = app_now;
      e.rdy = !m_pv;
    end
    sbq.push_back(e);
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("req_valid", 32'(req_valid), 32'(e.rv));
      if (e.rv) begin
        chk("x", 32'(x), 32'(e.x));
        chk("y", 32'(y), 32'(e.y));
      end
      chk("line_start", 32'(line_start), 32'(e.ls));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("de", 32'(de), 32'(e.de));
      chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
      chk("cfg_err", 32'(cfg_err), 32'(e.err));
      chk("cfg_applied", 32'(cfg_applied), 32'(e.app));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cfg(input mode_t m);
    cfg_h_act = CW'(m.ha); cfg_h_fp = CW'(m.hf); cfg_h_sync = CW'(m.hs); cfg_h_bp = CW'(m.hb);
    cfg_v_act = CW'(m.va); cfg_v_fp = CW'(m.vf); cfg_v_sync = CW'(m.vs); cfg_v_bp = CW'(m.vb);
    cfg_hs_pol = m.hp; cfg_vs_pol = m.vp;
  endtask

  task automatic offer(input mode_t m);
    set_cfg(m);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  function automatic int rf();
    return ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
  endfunction

  mode_t tiny, bad, alt;
  bit    found;

  initial begin
    tiny = mk(4, 1, 2, 1, 3, 1, 1, 1, 0, 0);
    bad  = mk(4, 1, 0, 1, 3, 1, 1, 1, 0, 0);
    alt  = mk(5, 2, 3, 2, 4, 2, 1, 2, 1, 0);
    reset_n = 1'b0; cfg_valid = 1'b0;
    set_cfg(tiny);
    repeat (3) step();
    reset_n = 1'b1;

    // default mode for a few lines, then a mid-frame mode change
    repeat (3300) step();
    offer(tiny);
    repeat (10560 + 100) step();

    // rejected config (zero sync width)
    offer(bad);
    repeat (100) step();

    // config offered exactly on the frame wrap cycle
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_t == htot(m_cur) * vtot(m_cur) - 1 && !m_pv) begin
        found = 1;
        offer(alt);
      end else begin
        step();
      end
    end
    chk("wrap_cycle_found", 32'(found), 32'd1);
    repeat (250) step();

    // randomized config traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        set_cfg(mk(rf(), rf(), rf(), rf(), rf(), rf(), rf(), rf(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        cfg_valid = 1'b1;
      end else begin
        cfg_valid = 1'b0;
      end
      step();
    end
    cfg_valid = 1'b0;

    // one-cycle reset mid-line with a config pending
    for (int i = 0; i < 1000 && m_pv; i++) step();
    offer(alt);
    repeat (3) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (10560 + 60) step();

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
